key_lut_cam: RTL

//   Writable, registered key->data lookup table (small CAM). Successor of the combinational keyed mux:
//   the table is held in internal registers, loaded at run time, not wired in as a constant LUT.

---
 rtl/key_lut_cam_if.sv | 32 +++
 rtl/key_lut_cam.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/key_lut_cam_if.sv
// rtl/key_lut_cam_if.sv - write/lookup/result bundle for the key_lut_cam lookup table
interface key_lut_cam_if #(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 8,
    parameter int DATA_LEN = 8
);
    localparam int IDX_W = $clog2(NR_KEY);

    logic                clr;
    logic                wr_en;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                lk_valid;
    logic [KEY_LEN-1:0]  lk_key;
    logic [DATA_LEN-1:0] default_out;
    logic                out_valid;
    logic [DATA_LEN-1:0] out;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [IDX_W:0]      count;
    logic                full;

    modport master (
        output clr, wr_en, wr_key, wr_data, lk_valid, lk_key, default_out,
        input  out_valid, out, hit, hit_idx, count, full
    );

    modport slave (
        input  clr, wr_en, wr_key, wr_data, lk_valid, lk_key, default_out,
        output out_valid, out, hit, hit_idx, count, full
    );
endinterface

// File: rtl/key_lut_cam.sv
// rtl/key_lut_cam.sv - writable registered key->data CAM with hit/index reporting and round-robin replacement
// Optional same-cycle write forwarding into the lookup path: define LUT_BYPASS_EN.
module key_lut_cam #(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 8,
    parameter int DATA_LEN = 8
) (
    input  logic           clk,
    input  logic           rst,
    key_lut_cam_if.slave   bus
);
    localparam int               IDX_W    = $clog2(NR_KEY);
    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(NR_KEY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

    logic [KEY_LEN-1:0]  key_mem  [NR_KEY];
    logic [DATA_LEN-1:0] data_mem [NR_KEY];
    logic [NR_KEY-1:0]   valid;
    logic [IDX_W:0]      count_q;
    logic [IDX_W-1:0]    victim;

    logic                out_valid_q;
    logic [DATA_LEN-1:0] out_q;
    logic                hit_q;
    logic [IDX_W-1:0]    hit_idx_q;

    logic                lk_hit;
    logic [IDX_W-1:0]    lk_idx;
    logic                wr_hit;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    free_idx;
    logic                full_w;
    logic                do_wr;
    logic                do_fill;
    logic                do_replace;
    logic [IDX_W-1:0]    wr_slot;

    logic                res_hit;
    logic [IDX_W-1:0]    res_idx;
    logic [DATA_LEN-1:0] res_data;

    // Descending scan so the lowest matching / lowest free index is the one left standing.
    always_comb begin
        lk_hit   = 1'b0;
        lk_idx   = '0;
        wr_hit   = 1'b0;
        wr_idx   = '0;
        free_idx = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (valid[i] && key_mem[i] == bus.lk_key) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (valid[i] && key_mem[i] == bus.wr_key) begin
                wr_hit = 1'b1;
                wr_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        full_w     = (count_q == FULL_CNT);
        do_wr      = bus.wr_en && !bus.clr;
        do_fill    = do_wr && !wr_hit && !full_w;
        do_replace = do_wr && !wr_hit && full_w;
        wr_slot    = wr_hit ? wr_idx : (full_w ? victim : free_idx);
    end

`ifdef LUT_BYPASS_EN
    logic fwd;
    always_comb begin
        fwd      = do_wr && (bus.wr_key == bus.lk_key);
        res_hit  = 1'b0;
        res_idx  = '0;
        res_data = data_mem[lk_idx];
        if (bus.clr) begin
            res_hit = 1'b0;
        end else if (fwd) begin
            res_hit  = 1'b1;
            res_idx  = wr_slot;
            res_data = bus.wr_data;
        end else begin
            res_hit = lk_hit;
            res_idx = lk_idx;
        end
    end
`else
    always_comb begin
        res_hit  = lk_hit;
        res_idx  = lk_idx;
        res_data = data_mem[lk_idx];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid       <= '0;
            count_q     <= '0;
            victim      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
        end else begin
            out_valid_q <= bus.lk_valid;
            if (bus.lk_valid) begin
                hit_q     <= res_hit;
                hit_idx_q <= res_hit ? res_idx : '0;
                out_q     <= res_hit ? res_data : bus.default_out;
            end
            if (bus.clr) begin
                valid   <= '0;
                count_q <= '0;
                victim  <= '0;
            end else begin
                if (do_wr) begin
                    valid[wr_slot] <= 1'b1;
                end
                if (do_fill) begin
                    count_q <= count_q + 1'b1;
                end
                if (do_replace) begin
                    victim <= (victim == LAST_IDX) ? '0 : victim + 1'b1;
                end
            end
        end
    end

    // Key/data storage is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            key_mem[wr_slot]  <= bus.wr_key;
            data_mem[wr_slot] <= bus.wr_data;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.hit       = hit_q;
    assign bus.hit_idx   = hit_idx_q;
    assign bus.count     = count_q;
    assign bus.full      = full_w;
endmodule
